// File: rtl/param_rom_stream_ctrl_if.sv
// Valid/ready stream carrying parameter-ROM words from the sequencer to its consumer.
interface param_rom_stream_ctrl_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_last;
  logic                  data_out_ready;

  modport master (output data_out, data_out_valid, data_out_last, input data_out_ready);
  modport slave  (input data_out, data_out_valid, data_out_last, output data_out_ready);
endinterface

// File: rtl/param_rom_stream_ctrl.sv
// Credited read scheduler for a registered-output parameter ROM: streams OUT_DEPTH words
// per pass, repeat_count passes per job, through a small FIFO that absorbs ROM latency.
module param_rom_stream_ctrl #(
  parameter int DATA_WIDTH   = 512,
  parameter int OUT_DEPTH    = 32,
  parameter int ROM_LATENCY  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_WIDTH = 16,
  parameter int ADDR_WIDTH   = $clog2(OUT_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] repeat_count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic                    rom_ce,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  param_rom_stream_ctrl_if.master stream
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [REPEAT_WIDTH-1:0] pass_cnt;
  logic [ROM_LATENCY-1:0]  tag_valid;
  logic [ROM_LATENCY-1:0]  tag_last;

  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        inflight;

  logic issue;
  logic issue_last;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_valid;
  logic fifo_full;
  logic drained;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + CNT_W'(tag_valid[i]);
  end

  // Credit counts words already owed to the FIFO, so a push can never find it full.
  assign issue      = (state == RUN) && ((inflight + fifo_count) < CNT_W'(FIFO_DEPTH));
  assign issue_last = (addr == LAST_ADDR);
  assign fifo_push  = tag_valid[ROM_LATENCY-1];
  assign fifo_valid = (fifo_count != '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_pop   = fifo_valid && stream.data_out_ready;
  // Looking through this cycle's pop lets done follow the final handshake by one cycle.
  assign drained    = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr     <= '0;
          pass_cnt <= repeat_count;
          state    <= (repeat_count != '0) ? RUN : DONE;
        end
        RUN: if (issue) begin
          if (issue_last) begin
            addr     <= '0;
            pass_cnt <= pass_cnt - REPEAT_WIDTH'(1);
            if (pass_cnt == REPEAT_WIDTH'(1)) state <= DRAIN;
          end else begin
            addr <= addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: if (drained) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline mirrors the ROM read latency; the oldest stage marks a valid rom_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= '0;
      tag_last  <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_last[0]  <= issue && issue_last;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
    end
  end

  // NOTE: FIFO storage is not reset; the outputs are gated by fifo_count, which is.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= rom_q;
      fifo_last[wr_ptr] <= tag_last[ROM_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && !fifo_pop && fifo_full));

  assign busy                  = (state != IDLE);
  assign done                  = (state == DONE);
  assign rom_ce                = (state == RUN) || (state == DRAIN);
  assign rom_addr              = (state == RUN) ? addr : '0;
  assign stream.data_out       = fifo_valid ? fifo_data[rd_ptr] : '0;
  assign stream.data_out_last  = fifo_valid && fifo_last[rd_ptr];
  assign stream.data_out_valid = fifo_valid;

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Randomized bench: random ROM contents and consumer stalls, checked against a beat-queue model.
module tb_param_rom_stream_ctrl;
  localparam int DW = 512;
  localparam int OD = 32;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int RW = 16;
  localparam int AW = $clog2(OD) + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] repeat_count = '0;
  logic          busy, done, rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] rom_q1 = '0;
  logic [DW-1:0] rom_mem [OD];

  param_rom_stream_ctrl_if #(.DATA_WIDTH(DW)) sif ();

  param_rom_stream_ctrl #(
    .DATA_WIDTH(DW), .OUT_DEPTH(OD), .ROM_LATENCY(RL), .FIFO_DEPTH(FD), .REPEAT_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_count(repeat_count),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_q(rom_q),
    .stream(sif)
  );

  always #5 clk = ~clk;

  // Two-stage registered ROM with a shared clock enable.
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_q1 <= rom_mem[rom_addr[AW-2:0]];
      rom_q  <= rom_q1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int job_cyc0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: fixed ready level, or random with a 30% stall rate.
  bit rand_ready = 0;
  bit ready_val = 1;
  initial begin
    sif.data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      sif.data_out_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : ready_val;
    end
  end

  // Scoreboard state, rebuilt for every job.
  beat_t exp_q[$];
  int    last_idx[$];
  int    beat_cnt, issued, accepted, first_valid, done_rel, done_cnt, bubbles, last_hs, mon_rel;
  bit    prev_ce, prev_stall, prev_done, saw_ce, saw_valid;
  logic  busy_after;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst) begin
      mon_rel = cyc - job_cyc0;
      // An issue shows up as rom_addr moving on the next cycle.
      if (prev_ce && rom_addr != prev_addr) issued++;
      prev_ce = rom_ce;
      prev_addr = rom_addr;
      checks++;
      if (issued - accepted > FD) begin
        errors++;
        $display("FAIL credit: outstanding %0d required <= %0d", issued - accepted, FD);
      end
      if (rom_ce) saw_ce = 1;
      if (prev_done) busy_after = busy;
      prev_done = done;
      if (done) begin
        done_cnt++;
        done_rel = mon_rel;
      end
      if (prev_stall) begin
        checks++;
        if (!sif.data_out_valid || sif.data_out !== prev_data || sif.data_out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: valid %0b data %h last %0b required data %h last %0b",
                   sif.data_out_valid, sif.data_out[31:0], sif.data_out_last, prev_data[31:0], prev_last);
        end
      end
      if (sif.data_out_valid) begin
        saw_valid = 1;
        if (first_valid < 0) first_valid = mon_rel;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got data %h with no beat expected", sif.data_out[31:0]);
        end else if (sif.data_out !== exp_q[0].data || sif.data_out_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL beat_%0d: got data %h last %0b required data %h last %0b", beat_cnt,
                   sif.data_out[31:0], sif.data_out_last, exp_q[0].data[31:0], exp_q[0].last);
        end
        if (sif.data_out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (sif.data_out_last) last_idx.push_back(beat_cnt);
          beat_cnt++;
          accepted++;
          last_hs = mon_rel;
        end
      end else if (first_valid >= 0 && exp_q.size() > 0 && sif.data_out_ready) begin
        bubbles++;
      end
      prev_stall = sif.data_out_valid && !sif.data_out_ready;
      prev_data = sif.data_out;
      prev_last = sif.data_out_last;
    end else begin
      prev_ce = 0;
      prev_stall = 0;
      prev_done = 0;
    end
  end

  // Builds the expected beat list from the job's rules and pulses start for cycle 0.
  task automatic start_job(input int reps);
    exp_q.delete();
    last_idx.delete();
    for (int p = 0; p < reps; p++)
      for (int a = 0; a < OD; a++) exp_q.push_back('{rom_mem[a], (a == OD - 1)});
    beat_cnt = 0; issued = 0; accepted = 0; first_valid = -1; done_rel = -1; done_cnt = 0;
    bubbles = 0; last_hs = -1; prev_ce = 0; prev_stall = 0; prev_done = 0;
    saw_ce = 0; saw_valid = 0; busy_after = 1'bx;
    repeat_count = RW'(reps);
    start = 1'b1;
    @(posedge clk);
    #1;
    job_cyc0 = cyc - 1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles, beats %0d", name, budget, beat_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rom_ce, rom_addr, sif.data_out_valid, sif.data_out_last} !== '0 || sif.data_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy %0b done %0b ce %0b addr %0d valid %0b last %0b required all 0",
               busy, done, rom_ce, rom_addr, sif.data_out_valid, sif.data_out_last);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pass();
    ready_val = 1;
    start_job(1);
    wait_done(200, "single");
    checks++;
    if (first_valid !== 4) begin errors++; $display("FAIL first_valid: got cycle %0d required 4", first_valid); end
    checks++;
    if (beat_cnt !== OD || exp_q.size() != 0) begin
      errors++; $display("FAIL single_count: got %0d beats required %0d", beat_cnt, OD);
    end
    checks++;
    if (last_idx.size() != 1 || last_idx[0] != OD - 1) begin
      errors++; $display("FAIL single_last: got %0d last beats required one at %0d", last_idx.size(), OD - 1);
    end
    checks++;
    if (done_cnt !== 1 || done_rel !== last_hs + 1) begin
      errors++; $display("FAIL single_done: got %0d pulses at cycle %0d required 1 at %0d", done_cnt, done_rel, last_hs + 1);
    end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %0b required 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    ready_val = 1;
    start_job(3);
    repeat (20) @(posedge clk);
    #1;
    repeat_count = 7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(400, "b2b");
    checks++;
    if (beat_cnt !== 3 * OD || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d beats required %0d", beat_cnt, 3 * OD);
    end
    checks++;
    if (last_idx.size() != 3 || last_idx[0] != 31 || last_idx[1] != 63 || last_idx[2] != 95) begin
      errors++; $display("FAIL b2b_last: got %0d last beats required 31/63/95", last_idx.size());
    end
    checks++;
    if (bubbles !== 0) begin errors++; $display("FAIL b2b_bubbles: got %0d required 0", bubbles); end
    checks++;
    if (first_valid !== 4 || done_cnt !== 1) begin
      errors++; $display("FAIL b2b_timing: first valid %0d done pulses %0d required 4 and 1", first_valid, done_cnt);
    end
  endtask

  task automatic test_random_ready();
    rand_ready = 1;
    start_job(2);
    wait_done(1000, "random");
    rand_ready = 0;
    ready_val = 1;
    checks++;
    if (beat_cnt !== 2 * OD || exp_q.size() != 0 || done_cnt !== 1) begin
      errors++; $display("FAIL random_count: got %0d beats %0d done required %0d and 1", beat_cnt, done_cnt, 2 * OD);
    end
  endtask

  task automatic test_zero_repeat();
    ready_val = 1;
    start_job(0);
    repeat_count = 5;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_done: done %0b busy %0b in cycle 1 required 1 1", done, busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_ignore: done %0b busy %0b in cycle 2 required 0 0", done, busy);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (saw_ce || saw_valid || done_cnt !== 1) begin
      errors++; $display("FAIL zero_quiet: ce %0b valid %0b done pulses %0d required 0 0 1", saw_ce, saw_valid, done_cnt);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    ready_val = 1;
    start_job(1);
    while (beat_cnt < 10 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (beat_cnt < 10) begin errors++; $display("FAIL areset_reach: got %0d beats required 10", beat_cnt); end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, rom_ce, rom_addr, sif.data_out_valid, sif.data_out_last} !== '0 || sif.data_out !== '0) begin
      errors++;
      $display("FAIL areset_outputs: busy %0b done %0b ce %0b addr %0d valid %0b required all 0",
               busy, done, rom_ce, rom_addr, sif.data_out_valid);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    start_job(1);
    wait_done(200, "restart");
    checks++;
    if (beat_cnt !== OD || exp_q.size() != 0 || first_valid !== 4) begin
      errors++; $display("FAIL restart: got %0d beats first valid %0d required %0d and 4", beat_cnt, first_valid, OD);
    end
  endtask

  task automatic test_stall();
    ready_val = 0;
    start_job(1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sif.data_out_valid !== 1'b1 || rom_addr !== AW'(4) || sif.data_out !== rom_mem[0]) begin
      errors++; $display("FAIL stall_buffer: valid %0b addr %0d required valid 1 addr 4 head word 0",
                         sif.data_out_valid, rom_addr);
    end
    checks++;
    if (issued !== FD || beat_cnt !== 0) begin
      errors++; $display("FAIL stall_issue: got %0d issued %0d accepted required %0d and 0", issued, beat_cnt, FD);
    end
    @(posedge clk);
    #1;
    ready_val = 1;
    wait_done(200, "stall");
    checks++;
    if (beat_cnt !== OD || exp_q.size() != 0 || done_rel !== last_hs + 1) begin
      errors++; $display("FAIL stall_resume: got %0d beats done at %0d required %0d beats done at %0d",
                         beat_cnt, done_rel, OD, last_hs + 1);
    end
  endtask

  initial begin
    for (int a = 0; a < OD; a++)
      for (int j = 0; j < DW / 32; j++) rom_mem[a][32*j +: 32] = $urandom;
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_random_ready();
    test_zero_repeat();
    test_async_reset();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
